issue_unit: RTL and testbench

Instruction sequencer that drives the control side of the `datapath` block. It accepts a stream of 32-bit instruction words over a valid/ready handshake and assembles each instruction from 2 or 3 words. It then presents one registered control bundle per instruction, with the write-enables asserted for exactly one issue cycle. It sits between the instruction source (memory or a test FIFO) and `datapath`; its outputs connect 1:1 to `datapath` inputs.

---
 rtl/rapids_pkg.sv | 38 +++
 rtl/issue_unit.sv | 198 +++++++++++++++++++
 tb/tb_issue_unit.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rapids_pkg.sv
// Shared definitions for the instruction sequencer: state encoding,
// instruction word field positions and the write-port collision rule.
package rapids_pkg;

    typedef enum logic [2:0] {
        ST_CTRL  = 3'd0,
        ST_MAIN  = 3'd1,
        ST_IMM   = 3'd2,
        ST_ISSUE = 3'd3,
        ST_HALT  = 3'd4
    } issue_state_t;

    // Ctrl word
    localparam int CTRL_ZERO_LSB    = 0;
    localparam int CTRL_CONST_A_BIT = 4;
    localparam int CTRL_HALT_BIT    = 5;
    localparam logic [31:0] CTRL_RSVD_MASK = 32'hFFFF_FFC0;

    // Main word
    localparam int MAIN_OP_LSB    = 29;
    localparam int MAIN_FORM_BIT  = 28;
    localparam int MAIN_VEC_LSB   = 26;
    localparam int MAIN_A_LSB     = 22;
    localparam int MAIN_B_LSB     = 18;
    localparam int MAIN_C_LSB     = 14;
    localparam int MAIN_D_LSB     = 10;
    localparam int MAIN_Y1_LSB    = 6;
    localparam int MAIN_Y2_LSB    = 2;
    localparam int MAIN_WRITE_LSB = 0;

    // Both ports writing the same register: port Y2 wins, so drop Y1's enable.
    function automatic logic [1:0] resolve_write(input logic [1:0] wr,
                                                 input logic [3:0] y1,
                                                 input logic [3:0] y2);
        return (wr == 2'b11 && y1 == y2) ? 2'b10 : wr;
    endfunction

endpackage

// File: rtl/issue_unit.sv
// Instruction sequencer: assembles ctrl/main/[imm] words into one registered
// control bundle for datapath, pulsing the write enables for a single cycle.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_CTRL  | waiting for ctrl word (zero_reg, const_a, halt, reserved)
// ST_MAIN  | waiting for main word (ALU controls, register indices)
// ST_IMM   | waiting for 32-bit immediate (only when const_a = 1)
// ST_ISSUE | one cycle: write enables valid, retired count bumps
// ST_HALT  | stopped until reset (halt request or illegal ctrl word)
module issue_unit
    import rapids_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_word,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [2:0]  op,
    output logic        form,
    output logic [1:0]  vec,
    output logic [3:0]  A,
    output logic [3:0]  B,
    output logic [3:0]  C,
    output logic [3:0]  D,
    output logic [3:0]  Y1,
    output logic [3:0]  Y2,
    output logic [3:0]  zero_reg,
    output logic        const_a,
    output logic [31:0] constant,
    output logic [1:0]  write,
    output logic        halted,
    output logic        illegal,
    output logic [31:0] retired
);

    issue_state_t state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic        form_q, form_d;
    logic [1:0]  vec_q, vec_d;
    logic [3:0]  a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic [3:0]  y1_q, y1_d, y2_q, y2_d;
    logic [3:0]  zero_reg_q, zero_reg_d;
    logic        const_a_q, const_a_d;
    logic [31:0] constant_q, constant_d;
    logic [1:0]  wr_pend_q, wr_pend_d;
    logic [1:0]  write_q, write_d;
    logic        halted_q, halted_d;
    logic        illegal_q, illegal_d;
    logic [31:0] retired_q, retired_d;
    logic        xfer;

    // Ready depends on state only, never on the incoming word.
    assign in_ready = (state_q == ST_CTRL) || (state_q == ST_MAIN) || (state_q == ST_IMM);
    assign xfer     = in_valid && in_ready;

    // Next-state and field capture; write enables are armed only on the
    // transition into ISSUE so the registered pulse lines up with that cycle.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        form_d     = form_q;
        vec_d      = vec_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        d_d        = d_q;
        y1_d       = y1_q;
        y2_d       = y2_q;
        zero_reg_d = zero_reg_q;
        const_a_d  = const_a_q;
        constant_d = constant_q;
        wr_pend_d  = wr_pend_q;
        write_d    = 2'b00;
        halted_d   = halted_q;
        illegal_d  = illegal_q;
        retired_d  = retired_q;

        case (state_q)
            ST_CTRL: begin
                if (xfer) begin
                    if ((in_word & CTRL_RSVD_MASK) != 32'd0) begin
                        illegal_d = 1'b1;
                        halted_d  = 1'b1;
                        state_d   = ST_HALT;
                    end else if (in_word[CTRL_HALT_BIT]) begin
                        halted_d  = 1'b1;
                        state_d   = ST_HALT;
                    end else begin
                        zero_reg_d = in_word[CTRL_ZERO_LSB +: 4];
                        const_a_d  = in_word[CTRL_CONST_A_BIT];
                        state_d    = ST_MAIN;
                    end
                end
            end
            ST_MAIN: begin
                if (xfer) begin
                    op_d      = in_word[MAIN_OP_LSB +: 3];
                    form_d    = in_word[MAIN_FORM_BIT];
                    vec_d     = in_word[MAIN_VEC_LSB +: 2];
                    a_d       = in_word[MAIN_A_LSB +: 4];
                    b_d       = in_word[MAIN_B_LSB +: 4];
                    c_d       = in_word[MAIN_C_LSB +: 4];
                    d_d       = in_word[MAIN_D_LSB +: 4];
                    y1_d      = in_word[MAIN_Y1_LSB +: 4];
                    y2_d      = in_word[MAIN_Y2_LSB +: 4];
                    wr_pend_d = resolve_write(in_word[MAIN_WRITE_LSB +: 2],
                                              in_word[MAIN_Y1_LSB +: 4],
                                              in_word[MAIN_Y2_LSB +: 4]);
                    if (const_a_q) begin
                        state_d = ST_IMM;
                    end else begin
                        write_d = wr_pend_d;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_IMM: begin
                if (xfer) begin
                    constant_d = in_word;
                    write_d    = wr_pend_q;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                retired_d = retired_q + 32'd1;
                state_d   = ST_CTRL;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_CTRL;
            end
        endcase
    end

    // State and bundle registers; reset drops any partial instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_CTRL;
            op_q       <= '0;
            form_q     <= 1'b0;
            vec_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            d_q        <= '0;
            y1_q       <= '0;
            y2_q       <= '0;
            zero_reg_q <= '0;
            const_a_q  <= 1'b0;
            constant_q <= '0;
            wr_pend_q  <= '0;
            write_q    <= '0;
            halted_q   <= 1'b0;
            illegal_q  <= 1'b0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            form_q     <= form_d;
            vec_q      <= vec_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            d_q        <= d_d;
            y1_q       <= y1_d;
            y2_q       <= y2_d;
            zero_reg_q <= zero_reg_d;
            const_a_q  <= const_a_d;
            constant_q <= constant_d;
            wr_pend_q  <= wr_pend_d;
            write_q    <= write_d;
            halted_q   <= halted_d;
            illegal_q  <= illegal_d;
            retired_q  <= retired_d;
        end
    end

    assign op       = op_q;
    assign form     = form_q;
    assign vec      = vec_q;
    assign A        = a_q;
    assign B        = b_q;
    assign C        = c_q;
    assign D        = d_q;
    assign Y1       = y1_q;
    assign Y2       = y2_q;
    assign zero_reg = zero_reg_q;
    assign const_a  = const_a_q;
    assign constant = constant_q;
    assign write    = write_q;
    assign halted   = halted_q;
    assign illegal  = illegal_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_issue_unit.sv
// Bench for issue_unit: table of directed instructions, randomized
// instruction stream against a field-level reference model, and
// hand-written sequences for gaps, halt/illegal, reset mid-instruction
// and retired-count wrap.
module tb_issue_unit;

    logic        clk;
    logic        rst;
    logic [31:0] in_word;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic        form;
    logic [1:0]  vec;
    logic [3:0]  A, B, C, D, Y1, Y2;
    logic [3:0]  zero_reg;
    logic        const_a;
    logic [31:0] constant;
    logic [1:0]  write;
    logic        halted;
    logic        illegal;
    logic [31:0] retired;

    issue_unit dut (
        .clk      (clk),
        .rst      (rst),
        .in_word  (in_word),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .form     (form),
        .vec      (vec),
        .A        (A),
        .B        (B),
        .C        (C),
        .D        (D),
        .Y1       (Y1),
        .Y2       (Y2),
        .zero_reg (zero_reg),
        .const_a  (const_a),
        .constant (constant),
        .write    (write),
        .halted   (halted),
        .illegal  (illegal),
        .retired  (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] exp_retired;
    logic [31:0] exp_constant;

    typedef struct {
        logic [31:0] ctrl;
        logic [31:0] main;
        logic [31:0] imm;
        logic [1:0]  exp_write;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_main(input logic [2:0] f_op, input logic f_form,
                                            input logic [1:0] f_vec,
                                            input logic [3:0] f_a, input logic [3:0] f_b,
                                            input logic [3:0] f_c, input logic [3:0] f_d,
                                            input logic [3:0] f_y1, input logic [3:0] f_y2,
                                            input logic [1:0] f_w);
        return {f_op, f_form, f_vec, f_a, f_b, f_c, f_d, f_y1, f_y2, f_w};
    endfunction

    function automatic logic [102:0] all_outputs();
        return {op, form, vec, A, B, C, D, Y1, Y2, zero_reg, const_a,
                constant, write, halted, illegal, retired};
    endfunction

    // Reset, check every output is zero, release; bench is left at a negedge.
    task automatic do_reset();
        in_valid = 1'b0;
        in_word  = 32'd0;
        rst      = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_outputs", {25'd0, all_outputs()}, 128'd0);
        rst = 1'b0;
        #1;
        chk("reset_ready", {127'd0, in_ready}, 128'd1);
        exp_retired  = 32'd0;
        exp_constant = 32'd0;
    endtask

    // Present one word after 'gap' idle cycles; returns at the negedge after acceptance.
    task automatic send(input logic [31:0] w, input int gap);
        bit ok;
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            chk("gap_write", {126'd0, write}, 128'd0);
        end
        in_valid = 1'b1;
        in_word  = w;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=ready_low expected=ready_high");
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_word  = $urandom;
    endtask

    // One full instruction (no halt, no reserved bits), checked against the model.
    task automatic do_instr(input logic [31:0] ctrl, input logic [31:0] main,
                            input logic [31:0] imm, input logic [1:0] exp_w, input int gap);
        int c0;
        logic has_imm;
        has_imm = ctrl[4];
        c0 = cyc;
        send(ctrl, gap);
        send(main, gap);
        if (has_imm) begin
            send(imm, gap);
            exp_constant = imm;
        end
        // ISSUE cycle
        chk("issue_write", {126'd0, write}, {126'd0, exp_w});
        chk("issue_fields", {98'd0, op, form, vec, A, B, C, D, Y1, Y2}, {98'd0, main[31:2]});
        chk("issue_zero_const_a", {123'd0, zero_reg, const_a}, {123'd0, ctrl[3:0], has_imm});
        chk("issue_constant", {96'd0, constant}, {96'd0, exp_constant});
        chk("issue_ready", {127'd0, in_ready}, 128'd0);
        if (gap == 0)
            chk("issue_latency", 128'(cyc - c0), has_imm ? 128'd3 : 128'd2);
        @(negedge clk);
        exp_retired = exp_retired + 32'd1;
        chk("post_write", {126'd0, write}, 128'd0);
        chk("post_retired", {96'd0, retired}, {96'd0, exp_retired});
        chk("post_ready", {127'd0, in_ready}, 128'd1);
        chk("post_fields_hold", {98'd0, op, form, vec, A, B, C, D, Y1, Y2}, {98'd0, main[31:2]});
    endtask

    function automatic logic [1:0] model_write(input logic [31:0] main);
        logic [1:0] w;
        w = main[1:0];
        if (w == 2'b11 && main[9:6] == main[5:2]) return 2'b10;
        return w;
    endfunction

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_word  = 32'd0;

        tbl[0] = '{32'h0,  mk_main(3'd1, 1'b0, 2'd0, 4'd1, 4'd2, 4'd0, 4'd0, 4'd3, 4'd0, 2'b01), 32'h0,         2'b01};
        tbl[1] = '{32'h10, mk_main(3'd0, 1'b0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd5, 4'd0, 2'b01), 32'hDEAD_BEEF, 2'b01};
        tbl[2] = '{32'h0,  mk_main(3'd2, 1'b1, 2'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd7, 4'd7, 2'b11), 32'h0,         2'b10};
        tbl[3] = '{32'h3,  mk_main(3'd7, 1'b0, 2'd3, 4'd8, 4'd9, 4'd10, 4'd11, 4'd2, 4'd9, 2'b11), 32'h0,       2'b11};
        tbl[4] = '{32'h1F, mk_main(3'd5, 1'b1, 2'd2, 4'd15, 4'd14, 4'd13, 4'd12, 4'd1, 4'd6, 2'b10), 32'h1234_5678, 2'b10};
        tbl[5] = '{32'h0,  mk_main(3'd3, 1'b0, 2'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 2'b00), 32'h0,         2'b00};

        do_reset();

        // Directed table, back-to-back
        for (int i = 0; i < 6; i++)
            do_instr(tbl[i].ctrl, tbl[i].main, tbl[i].imm, tbl[i].exp_write, 0);

        // Backpressure: same immediate instruction with 5-cycle gaps between words
        do_instr(tbl[1].ctrl, tbl[1].main, tbl[1].imm, tbl[1].exp_write, 5);
        do_instr(tbl[0].ctrl, tbl[0].main, tbl[0].imm, tbl[0].exp_write, 5);

        // Randomized stream
        for (int n = 0; n < 40; n++) begin
            logic [31:0] c, m, im;
            c  = $urandom & 32'h1F;
            m  = $urandom;
            im = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                m[5:2] = m[9:6];
                m[1:0] = 2'b11;
            end
            do_instr(c, m, im, model_write(m), int'($urandom_range(0, 3)));
        end

        // Retired count wrap
        force dut.retired_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.retired_q;
        @(negedge clk);
        chk("wrap_preload", {96'd0, retired}, {96'd0, 32'hFFFF_FFFF});
        exp_retired = 32'hFFFF_FFFF;
        do_instr(tbl[0].ctrl, tbl[0].main, tbl[0].imm, tbl[0].exp_write, 0);

        // Reset while waiting for the immediate
        do_reset();
        send(32'h10, 0);
        send(mk_main(3'd1, 1'b0, 2'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 2'b11), 0);
        in_valid = 1'b1;
        in_word  = 32'hCAFE_F00D;
        rst      = 1'b1;
        #1;
        chk("rst_imm_write", {126'd0, write}, 128'd0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_imm_outputs", {25'd0, all_outputs()}, 128'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rst_imm_no_write", {126'd0, write, retired}, 128'd0);
        end

        // Halt request
        do_reset();
        send(32'h20, 0);
        in_valid = 1'b1;
        in_word  = 32'd0;
        for (int k = 0; k < 5; k++) begin
            chk("halt_state", {124'd0, in_ready, halted, illegal, |write}, {124'd0, 4'b0100});
            @(negedge clk);
        end
        in_valid = 1'b0;

        // Reserved bit set in ctrl word
        do_reset();
        send(32'h40, 0);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("illegal_state", {124'd0, in_ready, halted, illegal, |write}, {124'd0, 4'b0110});
            @(negedge clk);
        end
        in_valid = 1'b0;

        // Unit recovers after reset and issues normally
        do_reset();
        do_instr(tbl[2].ctrl, tbl[2].main, tbl[2].imm, tbl[2].exp_write, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
